// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts one ALU operation per handshake, drives the
// registered operands into the ALU, waits SETTLE cycles, then captures
// the ALU result and flags into a response register. The last result is
// kept in an accumulator so requests can chain (A := previous w).
module alu_op_sequencer #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned OPW    = 3,
   parameter int unsigned SETTLE = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [OPW-1:0]   req_opc,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic             req_inc,
   input  logic             req_acc,
   output logic [WIDTH-1:0] alu_inA,
   output logic [WIDTH-1:0] alu_inB,
   output logic             alu_inc,
   output logic [OPW-1:0]   alu_opc,
   input  logic [WIDTH-1:0] alu_w,
   input  logic             alu_zer,
   input  logic             alu_neg,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_w,
   output logic             rsp_zer,
   output logic             rsp_neg,
   output logic             busy
);

   // Counter only has to hold SETTLE-1; keep at least one bit.
   localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   acc;

   // Sequencer FSM: accept -> settle -> capture -> hand off response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         acc       <= '0;
         req_ready <= 1'b1;
         busy      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_w     <= '0;
         rsp_zer   <= 1'b0;
         rsp_neg   <= 1'b0;
         alu_inA   <= '0;
         alu_inB   <= '0;
         alu_inc   <= 1'b0;
         alu_opc   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  alu_inA   <= req_acc ? acc : req_a;
                  alu_inB   <= req_b;
                  alu_inc   <= req_inc;
                  alu_opc   <= req_opc;
                  cnt       <= CNT_W'(SETTLE - 1);
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else begin
                  // Flags are taken from the ALU as is, never recomputed.
                  rsp_w     <= alu_w;
                  rsp_zer   <= alu_zer;
                  rsp_neg   <= alu_neg;
                  acc       <= alu_w;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (rsp_valid && rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: behavioural ALU stub, transaction-level
// reference model checked every cycle, plus directed literal checks.
module tb_alu_op_sequencer;

   localparam int unsigned WIDTH  = 16;
   localparam int unsigned OPW    = 3;
   localparam int unsigned SETTLE = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             req_valid;
   logic             req_ready;
   logic [OPW-1:0]   req_opc;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic             req_inc;
   logic             req_acc;
   logic [WIDTH-1:0] alu_inA;
   logic [WIDTH-1:0] alu_inB;
   logic             alu_inc;
   logic [OPW-1:0]   alu_opc;
   logic [WIDTH-1:0] alu_w;
   logic             alu_zer;
   logic             alu_neg;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_w;
   logic             rsp_zer;
   logic             rsp_neg;
   logic             busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_op_sequencer #(.WIDTH(WIDTH), .OPW(OPW), .SETTLE(SETTLE)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_opc(req_opc),
      .req_a(req_a), .req_b(req_b), .req_inc(req_inc), .req_acc(req_acc),
      .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_inc(alu_inc), .alu_opc(alu_opc),
      .alu_w(alu_w), .alu_zer(alu_zer), .alu_neg(alu_neg),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_w(rsp_w), .rsp_zer(rsp_zer), .rsp_neg(rsp_neg),
      .busy(busy)
   );

   // Behavioural ALU: add with carry, subtract, otherwise xor.
   function automatic logic [WIDTH-1:0] alu_fn(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic ci,
                                               input logic [OPW-1:0] op);
      case (op)
         3'd0:    return a + b + {15'd0, ci};
         3'd1:    return a - b;
         default: return a ^ b;
      endcase
   endfunction

   assign alu_w   = alu_fn(alu_inA, alu_inB, alu_inc, alu_opc);
   assign alu_zer = (alu_w == '0);
   assign alu_neg = alu_w[WIDTH-1];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: an operation is "in flight" from its accept cycle until
   // accept_cyc+SETTLE, then a response is "held" until the consumer takes it.
   bit               started  = 1'b0;
   bit               m_in_op  = 1'b0;
   bit               m_have   = 1'b0;
   int               cyc      = 0;
   int               acc_cyc  = 0;
   logic [WIDTH-1:0] m_acc, m_a, m_b, m_rw;
   logic             m_inc, m_rz, m_rn;
   logic [OPW-1:0]   m_opc;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         started <= 1'b1;
         m_in_op <= 1'b0;
         m_have  <= 1'b0;
         m_acc   <= '0;
         m_a     <= '0;
         m_b     <= '0;
         m_inc   <= 1'b0;
         m_opc   <= '0;
         m_rw    <= '0;
         m_rz    <= 1'b0;
         m_rn    <= 1'b0;
      end else if (!m_in_op && !m_have) begin
         if (req_valid) begin
            m_a     <= req_acc ? m_acc : req_a;
            m_b     <= req_b;
            m_inc   <= req_inc;
            m_opc   <= req_opc;
            acc_cyc <= cyc;
            m_in_op <= 1'b1;
         end
      end else if (m_in_op) begin
         if (cyc == acc_cyc + int'(SETTLE)) begin
            m_rw    <= alu_fn(m_a, m_b, m_inc, m_opc);
            m_rz    <= (alu_fn(m_a, m_b, m_inc, m_opc) == '0);
            m_rn    <= alu_fn(m_a, m_b, m_inc, m_opc) >= 16'h8000;
            m_acc   <= alu_fn(m_a, m_b, m_inc, m_opc);
            m_in_op <= 1'b0;
            m_have  <= 1'b1;
         end
      end else if (rsp_ready) begin
         m_have <= 1'b0;
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (started) begin
         check("req_ready", 32'(req_ready), 32'(!m_in_op && !m_have));
         check("busy",      32'(busy),      32'(m_in_op || m_have));
         check("rsp_valid", 32'(rsp_valid), 32'(m_have));
         check("rsp_w",     32'(rsp_w),     32'(m_rw));
         check("rsp_zer",   32'(rsp_zer),   32'(m_rz));
         check("rsp_neg",   32'(rsp_neg),   32'(m_rn));
         check("alu_inA",   32'(alu_inA),   32'(m_a));
         check("alu_inB",   32'(alu_inB),   32'(m_b));
         check("alu_inc",   32'(alu_inc),   32'(m_inc));
         check("alu_opc",   32'(alu_opc),   32'(m_opc));
      end
   end

   // Called at a negedge; returns at the negedge after the accept edge.
   task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic ci, input logic [OPW-1:0] op, input logic use_acc);
      int k = 0;
      req_a = a; req_b = b; req_inc = ci; req_opc = op; req_acc = use_acc;
      req_valid = 1'b1;
      while (!req_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (k >= 100) check("send_timeout", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      req_a   = WIDTH'($urandom);
      req_b   = WIDTH'($urandom);
      req_inc = 1'($urandom);
      req_opc = OPW'($urandom);
      req_acc = 1'($urandom);
   endtask

   // Wait for a response, optionally check literals, then take it after a stall.
   task automatic get_rsp(input bit lit, input logic [WIDTH-1:0] w,
                          input logic z, input logic n, input int hold);
      int k = 0;
      rsp_ready = 1'b0;
      while (!rsp_valid && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (k >= 100) check("rsp_timeout", 32'(rsp_valid), 32'd1);
      if (lit) begin
         check("lit_rsp_w",   32'(rsp_w),   32'(w));
         check("lit_rsp_zer", 32'(rsp_zer), 32'(z));
         check("lit_rsp_neg", 32'(rsp_neg), 32'(n));
      end
      repeat (hold) @(negedge clk);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
      req_a = '0; req_b = '0; req_inc = 1'b0; req_opc = '0; req_acc = 1'b0;

      // 1. reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_w",     32'(rsp_w),     32'd0);
      check("rst_alu_inA",   32'(alu_inA),   32'd0);
      rst = 1'b0;

      // 2. add with carry and response latency
      send(16'h0003, 16'h0004, 1'b1, 3'd0, 1'b0);
      check("t2_alu_inA",  32'(alu_inA),   32'h3);
      check("t2_valid_n0", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      check("t2_valid_n1", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      check("t2_valid_n2", 32'(rsp_valid), 32'd1);
      get_rsp(1'b1, 16'h0008, 1'b0, 1'b0, 0);

      // 3. chained subtract from accumulator
      send(16'h7777, 16'h0010, 1'b0, 3'd1, 1'b1);
      check("t3_alu_inA", 32'(alu_inA), 32'h8);
      get_rsp(1'b1, 16'hFFF8, 1'b0, 1'b1, 1);

      // 4. wrap to zero
      send(16'hFFFF, 16'h0001, 1'b0, 3'd0, 1'b0);
      get_rsp(1'b1, 16'h0000, 1'b1, 1'b0, 0);

      // 5. backpressure with a pending request
      send(16'h1111, 16'h2222, 1'b0, 3'd0, 1'b0);
      while (!rsp_valid) @(negedge clk);
      req_valid = 1'b1; req_a = 16'h4444; req_b = 16'h0001;
      req_inc = 1'b0; req_opc = 3'd0; req_acc = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t5_req_ready", 32'(req_ready), 32'd0);
         check("t5_alu_inA",   32'(alu_inA),   32'h1111);
         check("t5_rsp_w",     32'(rsp_w),     32'h3333);
         check("t5_rsp_valid", 32'(rsp_valid), 32'd1);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("t5_ready_after", 32'(req_ready), 32'd1);
      check("t5_alu_hold",    32'(alu_inA),   32'h1111);
      @(negedge clk);
      req_valid = 1'b0;
      check("t5_alu_new", 32'(alu_inA), 32'h4444);
      get_rsp(1'b1, 16'h4445, 1'b0, 1'b0, 0);

      // 6. reset during WAIT drops the op and clears the accumulator
      send(16'h0100, 16'h0001, 1'b0, 3'd0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
      check("t6_req_ready", 32'(req_ready), 32'd1);
      check("t6_busy",      32'(busy),      32'd0);
      send(16'hABCD, 16'h0005, 1'b0, 3'd0, 1'b1);
      get_rsp(1'b1, 16'h0005, 1'b0, 1'b0, 0);

      // Random traffic checked by the model
      for (int i = 0; i < 150; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
              OPW'($urandom_range(0, 3)), 1'($urandom));
         get_rsp(1'b0, '0, 1'b0, 1'b0, int'($urandom_range(0, 3)));
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
